apollo_resp_decoder: RTL and testbench

APOLLO_RESP_DECODER -- requirements
Module: apollo_resp_decoder

---
 rtl/apollo_resp_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_apollo_resp_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apollo_resp_decoder.sv
// Apollo response decoder.
// Tracks one outstanding command to the Apollo ATU over SPI and checks the
// word shifted back against it. Mismatches, timeouts, status changes and
// version reads go into a 4-deep first-word-fall-through event FIFO for the
// host. The last status and version payloads are kept as registers.
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   enable                Apollo selected; low flushes FSM, timer and FIFO
//   cmd_sent, cmd_word    command handed to the SPI link (opcode in [31:24])
//   resp_valid, resp_word word returned by the SPI transfer
//   evt_valid, evt_word   FIFO head ({code, payload}); evt_ready pops it
//   ovf_clear             clears the sticky overflow flag
//   atu_status            last accepted status payload
//   fw_version            last accepted firmware version
//   tuning                tune cycle in progress
//   overflow              sticky: an event was dropped on a full FIFO
//   err_count             mismatch + timeout count, saturating
//
// state     | meaning
// IDLE      | no command outstanding; any response is unsolicited
// WAIT_RESP | command latched, timer running until a response arrives
// DECODE    | one cycle: compare latched response with latched command

module apollo_resp_decoder #(
  parameter int ClockFrequency = 30000,
  parameter int RespTimeoutMs  = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_sent,
  input  logic [31:0] cmd_word,
  input  logic        resp_valid,
  input  logic [31:0] resp_word,
  output logic        evt_valid,
  output logic [31:0] evt_word,
  input  logic        evt_ready,
  input  logic        ovf_clear,
  output logic [23:0] atu_status,
  output logic [15:0] fw_version,
  output logic        tuning,
  output logic        overflow,
  output logic [7:0]  err_count
);

  localparam int          TicksInt  = ClockFrequency * RespTimeoutMs / 1000;
  localparam logic [15:0] TicksLast = 16'(TicksInt - 1);

  localparam logic [7:0] EvtMismatch = 8'h02;
  localparam logic [7:0] EvtTimeout  = 8'h03;
  localparam logic [7:0] EvtStatus   = 8'h06;
  localparam logic [7:0] EvtVersion  = 8'h07;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, DECODE} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_timer, w_timer_next;
  logic [31:0] r_cmd, w_cmd_next;
  logic [31:0] r_resp, w_resp_next;
  logic [23:0] r_atu, w_atu_next;
  logic [15:0] r_fw, w_fw_next;
  logic        r_tuning, w_tuning_next;
  logic        r_first, w_first_next;
  logic        r_overflow;
  logic [7:0]  r_err;
  logic        w_push;
  logic [31:0] w_push_word;
  logic        w_err_inc;
  logic [7:0]  w_op;

  logic [31:0] r_mem [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic        w_pop, w_accept, w_drop;

  assign w_op = r_cmd[31:24];

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_cmd_next    = r_cmd;
    w_resp_next   = r_resp;
    w_atu_next    = r_atu;
    w_fw_next     = r_fw;
    w_tuning_next = r_tuning;
    w_first_next  = r_first;
    w_push        = 1'b0;
    w_push_word   = '0;
    w_err_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_sent) begin
          w_cmd_next   = cmd_word;
          w_timer_next = '0;
          w_state_next = WAIT_RESP;
        end
        if (resp_valid) begin
          w_push      = 1'b1;
          w_push_word = {EvtMismatch, 24'd0};
          w_err_inc   = 1'b1;
        end
      end
      WAIT_RESP: begin
        // A response in the same cycle as a new command belongs to the old one.
        if (resp_valid) begin
          w_resp_next  = resp_word;
          w_state_next = DECODE;
        end else if (cmd_sent) begin
          w_cmd_next   = cmd_word;
          w_timer_next = '0;
        end else if (r_timer == TicksLast) begin
          w_push       = 1'b1;
          w_push_word  = {EvtTimeout, w_op, 16'd0};
          w_err_inc    = 1'b1;
          w_timer_next = '0;
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      DECODE: begin
        w_state_next = IDLE;
        w_timer_next = '0;
        if (w_op == 8'd6 || w_op == 8'd7) begin
          if (r_resp[31:24] != w_op) begin
            w_push      = 1'b1;
            w_push_word = {EvtMismatch, r_cmd[23:0]};
            w_err_inc   = 1'b1;
          end else if (w_op == 8'd6) begin
            w_tuning_next = r_resp[0];
            if (r_resp[23:0] != r_atu || r_first) begin
              w_atu_next   = r_resp[23:0];
              w_first_next = 1'b0;
              w_push       = 1'b1;
              w_push_word  = {EvtStatus, r_resp[23:0]};
            end
          end else begin
            w_fw_next   = r_resp[15:0];
            w_push      = 1'b1;
            w_push_word = {EvtVersion, 8'd0, r_resp[15:0]};
          end
        end else begin
          // Set-type commands (and unknown opcodes) are acked by an exact echo.
          if (r_resp != r_cmd) begin
            w_push      = 1'b1;
            w_push_word = {EvtMismatch, r_cmd[23:0]};
            w_err_inc   = 1'b1;
          end else if (w_op == 8'd4) begin
            w_tuning_next = 1'b1;
          end else if (w_op == 8'd5) begin
            w_tuning_next = 1'b0;
          end
        end
        // A back-to-back command is accepted while the previous one decodes.
        if (cmd_sent) begin
          w_cmd_next   = cmd_word;
          w_state_next = WAIT_RESP;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  assign w_pop    = evt_ready && (r_count != 3'd0);
  assign w_accept = w_push && ((r_count != 3'd4) || w_pop);
  assign w_drop   = w_push && (r_count == 3'd4) && !w_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_cmd    <= '0;
      r_resp   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!enable) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_cmd   <= w_cmd_next;
      r_resp  <= w_resp_next;
      if (w_accept) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enable && w_accept) r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_atu      <= '0;
      r_fw       <= '0;
      r_tuning   <= 1'b0;
      r_first    <= 1'b1;
      r_overflow <= 1'b0;
      r_err      <= '0;
    end else if (enable) begin
      r_atu    <= w_atu_next;
      r_fw     <= w_fw_next;
      r_tuning <= w_tuning_next;
      r_first  <= w_first_next;
      // A drop in the same cycle as a clear must stay visible.
      if (w_drop)         r_overflow <= 1'b1;
      else if (ovf_clear) r_overflow <= 1'b0;
      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  assign evt_valid  = (r_count != 3'd0);
  assign evt_word   = evt_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign atu_status = r_atu;
  assign fw_version = r_fw;
  assign tuning     = r_tuning;
  assign overflow   = r_overflow;
  assign err_count  = r_err;

endmodule

// File: tb/tb_apollo_resp_decoder.sv
module tb_apollo_resp_decoder;

  localparam int Ticks = 3000;

  logic        clock = 1'b0;
  logic        reset, enable, cmd_sent, resp_valid, evt_ready, ovf_clear;
  logic [31:0] cmd_word, resp_word;
  logic        evt_valid, tuning, overflow;
  logic [31:0] evt_word;
  logic [23:0] atu_status;
  logic [15:0] fw_version;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  apollo_resp_decoder dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cmd_sent(cmd_sent), .cmd_word(cmd_word),
    .resp_valid(resp_valid), .resp_word(resp_word),
    .evt_valid(evt_valid), .evt_word(evt_word), .evt_ready(evt_ready),
    .ovf_clear(ovf_clear), .atu_status(atu_status), .fw_version(fw_version),
    .tuning(tuning), .overflow(overflow), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] resp;
    int          gap;
    logic        exp_evt;
    logic [31:0] exp_word;
    logic [7:0]  exp_err;
    logic        exp_tuning;
    logic [23:0] exp_atu;
    logic [15:0] exp_fw;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_cmd(input logic [31:0] c);
    cmd_word = c;
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
  endtask

  // Command, gap cycles, response; optional clear/ready during the DECODE cycle.
  task automatic txn(input logic [31:0] c, input logic [31:0] r, input int gap,
                     input logic clr, input logic rdy);
    pulse_cmd(c);
    repeat (gap) tick();
    resp_word  = r;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    ovf_clear  = clr;
    evt_ready  = rdy;
    tick();
    ovf_clear  = 1'b0;
    evt_ready  = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    chk({name, "_valid"}, 32'(evt_valid), 32'd1);
    chk({name, "_word"}, evt_word, exp);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h04000000, 32'h04000000, 40, 1'b0, 32'h0,        8'd0, 1'b1, 24'h0,  16'h0};
    vecs[1]  = '{32'h06000000, 32'h06000005, 3,  1'b1, 32'h06000005, 8'd0, 1'b1, 24'h5,  16'h0};
    vecs[2]  = '{32'h06000000, 32'h06000005, 3,  1'b0, 32'h0,        8'd0, 1'b1, 24'h5,  16'h0};
    vecs[3]  = '{32'h01A12345, 32'h01A12344, 5,  1'b1, 32'h02A12345, 8'd1, 1'b1, 24'h5,  16'h0};
    vecs[4]  = '{32'h05000000, 32'h05000000, 2,  1'b0, 32'h0,        8'd1, 1'b0, 24'h5,  16'h0};
    vecs[5]  = '{32'h07000000, 32'h0700BEEF, 4,  1'b1, 32'h0700BEEF, 8'd1, 1'b0, 24'h5,  16'hBEEF};
    vecs[6]  = '{32'h07000000, 32'h06001234, 1,  1'b1, 32'h02000000, 8'd2, 1'b0, 24'h5,  16'hBEEF};
    vecs[7]  = '{32'h06000000, 32'h06000005, 0,  1'b0, 32'h0,        8'd2, 1'b1, 24'h5,  16'hBEEF};
    vecs[8]  = '{32'h06000000, 32'h060000A2, 7,  1'b1, 32'h060000A2, 8'd2, 1'b0, 24'hA2, 16'hBEEF};
    vecs[9]  = '{32'h03000000, 32'h03000001, 2,  1'b1, 32'h02000000, 8'd3, 1'b0, 24'hA2, 16'hBEEF};
    vecs[10] = '{32'h04000000, 32'h04000000, 2,  1'b0, 32'h0,        8'd3, 1'b1, 24'hA2, 16'hBEEF};

    reset = 1'b1; enable = 1'b1; cmd_sent = 1'b0; resp_valid = 1'b0;
    evt_ready = 1'b0; ovf_clear = 1'b0; cmd_word = '0; resp_word = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_word", evt_word, 32'd0);
    chk("rst_atu", 32'(atu_status), 32'd0);
    chk("rst_fw", 32'(fw_version), 32'd0);
    chk("rst_tuning", 32'(tuning), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);

    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].cmd, vecs[i].resp, vecs[i].gap, 1'b0, 1'b0);
      chk($sformatf("v%0d_evt_valid", i), 32'(evt_valid), 32'(vecs[i].exp_evt));
      if (vecs[i].exp_evt) chk($sformatf("v%0d_evt_word", i), evt_word, vecs[i].exp_word);
      chk($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_tuning", i), 32'(tuning), 32'(vecs[i].exp_tuning));
      chk($sformatf("v%0d_atu", i), 32'(atu_status), 32'(vecs[i].exp_atu));
      chk($sformatf("v%0d_fw", i), 32'(fw_version), 32'(vecs[i].exp_fw));
      if (evt_valid) begin
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
      end
    end

    // Timeout exactly at the terminal tick, then FSM must be back in IDLE.
    pulse_cmd(32'h02000200);
    repeat (Ticks - 1) tick();
    chk("to_early_valid", 32'(evt_valid), 32'd0);
    tick();
    chk("to_valid", 32'(evt_valid), 32'd1);
    chk("to_word", evt_word, 32'h03020000);
    chk("to_err", 32'(err_count), 32'd4);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    resp_word = 32'h02000200; resp_valid = 1'b1; tick(); resp_valid = 1'b0; tick();
    chk("to_idle_unsol_word", evt_word, 32'h02000000);
    chk("to_idle_unsol_err", 32'(err_count), 32'd5);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // Response on the terminal tick beats the timeout.
    pulse_cmd(32'h02000200);
    repeat (Ticks - 1) tick();
    resp_word = 32'h02000200; resp_valid = 1'b1; tick(); resp_valid = 1'b0;
    tick(); tick();
    chk("race_evt_valid", 32'(evt_valid), 32'd0);
    chk("race_err", 32'(err_count), 32'd5);

    // Fill the FIFO and overflow it.
    for (int i = 0; i < 5; i++) txn(32'h07000000, 32'h07000010 + 32'(i), 1, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_fw", 32'(fw_version), 32'h0014);
    chk("ovf_head", evt_word, 32'h07000010);
    txn(32'h07000000, 32'h07000015, 1, 1'b1, 1'b0);
    chk("ovf_clear_on_drop", 32'(overflow), 32'd1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    txn(32'h07000000, 32'h07000016, 1, 1'b0, 1'b1);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    pop_chk("pop0", 32'h07000011);
    pop_chk("pop1", 32'h07000012);
    pop_chk("pop2", 32'h07000013);
    pop_chk("pop3", 32'h07000016);
    chk("drained_valid", 32'(evt_valid), 32'd0);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // Enable low flushes queued events but keeps registers.
    txn(32'h07000000, 32'h07000021, 1, 1'b0, 1'b0);
    txn(32'h07000000, 32'h07000022, 1, 1'b0, 1'b0);
    chk("pre_flush_head", evt_word, 32'h07000021);
    enable = 1'b0; tick(); tick();
    enable = 1'b1; tick();
    chk("flush_valid", 32'(evt_valid), 32'd0);
    chk("flush_fw", 32'(fw_version), 32'h0022);
    chk("flush_err", 32'(err_count), 32'd5);
    txn(32'h07000000, 32'h07000023, 1, 1'b0, 1'b0);
    pop_chk("post_flush", 32'h07000023);

    // Reset in WAIT_RESP discards the command; first status after reset reports.
    pulse_cmd(32'h02000200);
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (Ticks + 10) tick();
    chk("rst_wait_valid", 32'(evt_valid), 32'd0);
    chk("rst_wait_err", 32'(err_count), 32'd0);
    chk("rst_wait_fw", 32'(fw_version), 32'd0);
    txn(32'h06000000, 32'h06000000, 1, 1'b0, 1'b0);
    pop_chk("first_status", 32'h06000000);

    // Error counter saturation.
    resp_word = 32'h0; resp_valid = 1'b1; evt_ready = 1'b1;
    repeat (260) tick();
    resp_valid = 1'b0; evt_ready = 1'b0;
    tick();
    chk("err_saturate", 32'(err_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
